// File: rtl/ram8_access_arbiter.sv
// ram8_access_arbiter: shares one RAM8-style memory between NUM_REQ requesters with a one-cycle ack.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for lowest-index-wins selection.
module ram8_access_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*WIDTH-1:0]  wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [WIDTH-1:0]          rdata,
    input  logic [WIDTH-1:0]          ram_out,
    output logic [WIDTH-1:0]          ram_in,
    output logic                      ram_load,
    output logic [ADDR_W-1:0]         ram_address,
    output logic                      busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  win_idx;
    logic [ADDR_W-1:0] lat_addr;
    logic [WIDTH-1:0]  lat_data;
    logic              lat_we;
    logic              found;
    logic              arbitrating;

    assign arbitrating = (state == IDLE) || (state == DONE);

`ifdef ARB_FIXED_PRIORITY_EN
    // Lowest index wins and nothing is masked, so a request held past its ack is served again.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [NUM_REQ-1:0] cand_req;
    int                 cand;

    // Scan downward so the last hit is the nearest index after last_idx; the acked index is masked.
    always_comb begin
        cand_req = req;
        if (state == DONE) begin
            cand_req[gnt_idx] = 1'b0;
        end
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last_idx) + k) % NUM_REQ;
            if (cand_req[IDX_W'(cand)]) begin
                found   = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = found ? ACCESS : IDLE;
            ACCESS:     next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last_idx <= IDX_W'(NUM_REQ - 1);
            lat_addr <= '0;
            lat_data <= '0;
            lat_we   <= 1'b0;
            ack      <= '0;
            rdata    <= '0;
        end else begin
            state <= next_state;
            ack   <= '0;
            if (state == ACCESS) begin
                rdata        <= ram_out;
                ack[gnt_idx] <= 1'b1;
            end
            if (arbitrating && found) begin
                gnt_idx  <= win_idx;
                last_idx <= win_idx;
                lat_addr <= addr[int'(win_idx) * ADDR_W +: ADDR_W];
                lat_data <= wdata[int'(win_idx) * WIDTH +: WIDTH];
                lat_we   <= we[win_idx];
            end
        end
    end

    // Reset gates the write strobe combinationally so an interrupted write never lands.
    assign ram_load    = (state == ACCESS) && lat_we && !reset;
    assign ram_address = lat_addr;
    assign ram_in      = lat_data;
    assign busy        = (state == ACCESS);

endmodule

// File: tb/tb_ram8_access_arbiter.sv
// Scoreboard bench for ram8_access_arbiter with a behavioural RAM8 attached to the memory port.
module tb_ram8_access_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int ADDR_W  = 3;

    localparam logic [3:0] rr_seq [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    localparam logic [3:0] rst_seq [4] = '{4'h0, 4'h1, 4'h0, 4'h8};
    localparam logic [3:0] drop_seq [4] = '{4'h0, 4'h4, 4'h0, 4'h0};

    typedef struct packed {
        logic [NUM_REQ-1:0] ack;
        logic [WIDTH-1:0]   data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*WIDTH-1:0]  wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [WIDTH-1:0]          rdata;
    logic [WIDTH-1:0]          ram_out;
    logic [WIDTH-1:0]          ram_in;
    logic                      ram_load;
    logic [ADDR_W-1:0]         ram_address;
    logic                      busy;

    logic                      mem_clr;
    logic [WIDTH-1:0]          mem [8];
    exp_t                      exp_q [$];
    exp_t                      mon_e;
    exp_t                      push_e;
    int                        errors = 0;
    int                        checks = 0;

    always #5 clk = ~clk;

    ram8_access_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rdata       (rdata),
        .ram_out     (ram_out),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .busy        (busy)
    );

    // RAM8 model: combinational read, write on the rising edge when load is high.
    assign ram_out = mem[ram_address];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (ram_load) begin
            mem[ram_address] <= ram_in;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectAck(input logic [NUM_REQ-1:0] a, input logic [WIDTH-1:0] d);
        push_e = {a, d};
        exp_q.push_back(push_e);
    endtask

    // Single access from IDLE: checks the ACCESS cycle, then waits (bounded) for the ack.
    task automatic applyStimulus(input int idx, input logic w, input logic [ADDR_W-1:0] a,
                                 input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_rd);
        int cyc = 0;
        expectAck(NUM_REQ'(1 << idx), exp_rd);
        req[idx] = 1'b1;
        we[idx]  = w;
        addr[idx*ADDR_W +: ADDR_W] = a;
        wdata[idx*WIDTH +: WIDTH]  = d;
        do begin
            step();
            cyc++;
            if (cyc == 1) begin
                checkOutput("busy_in_access", busy, 1);
                checkOutput("ram_load_in_access", ram_load, w);
                checkOutput("ram_address_in_access", ram_address, a);
                if (w) checkOutput("ram_in_in_access", ram_in, d);
            end
        end while (ack[idx] !== 1'b1 && cyc < 10);
        checkOutput("ack_latency", cyc, 2);
        req[idx] = 1'b0;
        we[idx]  = 1'b0;
        step();
    endtask

    // Monitor: every ack pulse pops one expected response.
    always @(negedge clk) begin
        if (!reset && !$isunknown(ack) && ack != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack: got ack=%b, expected no ack", ack);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_ack", ack, mon_e.ack);
                checkOutput("sb_rdata", rdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        mem_clr = 1'b1;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        step();
        step();
        mem_clr = 1'b0;
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ram_load", ram_load, 0);
        reset = 1'b0;
        step();

        $display("[TB] write then read by requester 0");
        applyStimulus(0, 1'b1, 3'd5, 16'hBEEF, 16'h0000);
        applyStimulus(0, 1'b0, 3'd5, 16'h0000, 16'hBEEF);

        $display("[TB] write by requester 1 returns old word, read by requester 2");
        applyStimulus(1, 1'b1, 3'd3, 16'h1234, 16'h0000);
        applyStimulus(2, 1'b0, 3'd3, 16'h0000, 16'h1234);

        reset = 1'b1;
        step();
        checkOutput("reset_pulse_busy", busy, 0);
        reset = 1'b0;

        $display("[TB] all four requesting continuously");
        addr = {3'd5, 3'd0, 3'd3, 3'd5};
        we   = '0;
        expectAck(4'b0001, 16'hBEEF);
        expectAck(4'b0010, 16'h1234);
        expectAck(4'b0100, 16'h0000);
        expectAck(4'b1000, 16'hBEEF);
        expectAck(4'b0001, 16'hBEEF);
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("rr_ack_seq", ack, rr_seq[i]);
        end
        req = '0;
        step();
        step();

        $display("[TB] reset during a write access");
        we[2] = 1'b1;
        addr[2*ADDR_W +: ADDR_W] = 3'd7;
        wdata[2*WIDTH +: WIDTH]  = 16'hFFFF;
        req[2] = 1'b1;
        step();
        checkOutput("wr_busy_before_reset", busy, 1);
        checkOutput("wr_load_before_reset", ram_load, 1);
        reset = 1'b1;
        req   = '0;
        we    = '0;
        #1;
        checkOutput("ram_load_under_reset", ram_load, 0);
        step();
        checkOutput("no_ack_after_reset", ack, 0);
        checkOutput("idle_after_reset", busy, 0);
        reset = 1'b0;
        addr[0*ADDR_W +: ADDR_W] = 3'd7;
        addr[3*ADDR_W +: ADDR_W] = 3'd7;
        expectAck(4'b0001, 16'h0000);
        expectAck(4'b1000, 16'h0000);
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("post_reset_ack_seq", ack, rst_seq[i]);
            if (i == 1) req[0] = 1'b0;
            if (i == 3) req[3] = 1'b0;
        end
        step();

        $display("[TB] requests dropped after and before grant");
        addr[2*ADDR_W +: ADDR_W] = 3'd3;
        addr[3*ADDR_W +: ADDR_W] = 3'd1;
        expectAck(4'b0100, 16'h1234);
        req = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("drop_ack_seq", ack, drop_seq[i]);
            if (i == 0) req = '0;
        end

        step();
        step();
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
